riscv_pc_unit: RTL and testbench

// - Parametrised program-counter / next-PC unit for the RV32I single-cycle core.
// - Holds PC and computes sequential, JAL, JALR and taken-branch targets.
// - Produces the link address for rd writeback, detects the halt opcode and

---
 rtl/riscv_pc_unit.sv | 159 +++++++++++++++
 tb/tb_riscv_pc_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pc_unit.sv
// Program-counter / next-PC unit for the RV32I single-cycle core.
// Define RISCV_PC_RAS_EN to add the checking-only return-address stack.
module riscv_pc_unit #(
  parameter int              PC_W      = 11,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  input  logic [31:0]     instr,
  input  logic [31:0]     rs1_val,
  input  logic            branch_taken,
  input  logic            stall,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_plus,
  output logic [PC_W-1:0] PC_next,
  output logic [31:0]     link_addr,
  output logic            link_we,
  output logic            run,
  output logic            misalign,
  output logic [31:0]     instret
`ifdef RISCV_PC_RAS_EN
  ,
  output logic            ras_mismatch,
  output logic [15:0]     ras_miss_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic [31:0] imm_i, imm_b, imm_j;
  logic [31:0] pc_ext, seq32, target32;
  logic        is_jal, is_jalr, is_branch, is_halt;
  logic        redirect, misaligned, retire;
  logic        unused_bits;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_halt   = (opcode == 7'b1111111);

  // All target arithmetic is 32-bit; only the low PC_W bits reach the PC.
  assign pc_ext  = {{(32-PC_W){1'b0}}, PC};
  assign seq32   = pc_ext + 32'd4;
  assign PC_plus = seq32[PC_W-1:0];

  always_comb begin
    target32 = seq32;
    redirect = 1'b0;
    if (is_jal) begin
      target32 = pc_ext + imm_j;
      redirect = 1'b1;
    end else if (is_jalr) begin
      target32 = (rs1_val + imm_i) & ~32'd1;
      redirect = 1'b1;
    end else if (is_branch && branch_taken) begin
      target32 = pc_ext + imm_b;
      redirect = 1'b1;
    end
  end

  assign misaligned = redirect && target32[1];

  // stall takes priority over halt and fault detection: nothing commits.
  always_comb begin
    state_next = state_reg;
    PC_next    = PC;
    retire     = 1'b0;
    if (state_reg == S_RUN && !stall) begin
      if (is_halt) begin
        state_next = S_HALT;
        retire     = 1'b1;
      end else if (misaligned) begin
        state_next = S_FAULT;
      end else begin
        PC_next = target32[PC_W-1:0];
        retire  = 1'b1;
      end
    end
  end

  assign run       = (state_reg == S_RUN);
  assign link_addr = {{(32-PC_W){1'b0}}, PC_plus};
  assign link_we   = (is_jal || is_jalr) && (rd != 5'd0) && run && !stall;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      PC        <= RESET_PC;
      state_reg <= S_RUN;
      misalign  <= 1'b0;
      instret   <= '0;
    end else begin
      PC        <= PC_next;
      state_reg <= state_next;
      instret   <= instret + {31'd0, retire};
      if (state_next == S_FAULT && state_reg == S_RUN)
        misalign <= 1'b1;
    end
  end

`ifdef RISCV_PC_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   ras_sp;
  logic [AW:0]     ras_cnt;
  logic            commit, ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;

  // Halts retire but never redirect, so only non-halt retires touch the stack.
  assign commit   = retire && !is_halt;
  assign ras_push = commit && (is_jal || is_jalr) && (rd == 5'd1 || rd == 5'd5);
  assign ras_pop  = commit && is_jalr && (rs1 == 5'd1 || rs1 == 5'd5) && (rd == 5'd0)
                    && (ras_cnt != '0);
  assign ras_top  = ras_mem[ras_sp - 1'b1];

  always_ff @(posedge CLOCK_50) begin
    if (ras_push)
      ras_mem[ras_sp] <= PC_plus;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ras_sp       <= '0;
      ras_cnt      <= '0;
      ras_mismatch <= 1'b0;
      ras_miss_cnt <= '0;
    end else begin
      ras_mismatch <= 1'b0;
      if (ras_push) begin
        ras_sp <= ras_sp + 1'b1;
        if (ras_cnt != (AW+1)'(RAS_DEPTH))
          ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_pop) begin
        ras_sp  <= ras_sp - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
        if (ras_top != PC_next) begin
          ras_mismatch <= 1'b1;
          if (ras_miss_cnt != 16'hFFFF)
            ras_miss_cnt <= ras_miss_cnt + 16'd1;
        end
      end
    end
  end
`endif

  assign unused_bits = ^{target32[31:PC_W], seq32[31:PC_W], instr[14:12], rs1};

endmodule

// File: tb/tb_riscv_pc_unit.sv
// Self-checking bench for riscv_pc_unit: directed scenarios plus a randomized
// run compared against an instruction-level reference model.
module tb_riscv_pc_unit;

  typedef enum int {K_ALU, K_JAL, K_JALR, K_BR, K_HALT} kind_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h00000013;
  logic [31:0] rs1_val = '0;
  logic        branch_taken = 1'b0;
  logic        stall = 1'b0;

  logic [10:0] pc, pc_plus, pc_next;
  logic [31:0] link_addr, instret;
  logic        link_we, run, misalign;
  logic [10:0] w2_pc, w2_pc_plus, w2_pc_next;
  logic [31:0] w2_link_addr, w2_instret;
  logic        w2_link_we, w2_run, w2_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC, state (0 run, 1 halt, 2 fault), counters.
  logic [31:0] m_pc, m_instret, n_pc, n_instret;
  int          m_state, n_state;
  bit          m_mis, n_mis;
  logic [31:0] e_next, e_plus;
  bit          e_lwe;

  always #5 clk = ~clk;

  riscv_pc_unit dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .instr(instr), .rs1_val(rs1_val),
    .branch_taken(branch_taken), .stall(stall), .PC(pc), .PC_plus(pc_plus),
    .PC_next(pc_next), .link_addr(link_addr), .link_we(link_we), .run(run),
    .misalign(misalign), .instret(instret)
  );

  riscv_pc_unit #(.PC_W(11), .RESET_PC(11'h7F8), .RAS_DEPTH(4)) dut_wrap (
    .CLOCK_50(clk), .RESET_N(rst_n), .instr(instr), .rs1_val(rs1_val),
    .branch_taken(branch_taken), .stall(stall), .PC(w2_pc), .PC_plus(w2_pc_plus),
    .PC_next(w2_pc_next), .link_addr(w2_link_addr), .link_we(w2_link_we), .run(w2_run),
    .misalign(w2_misalign), .instret(w2_instret)
  );

  function automatic logic [31:0] enc(input kind_t k, input int imm, input int rd, input int rs1);
    logic [31:0] iv;
    logic [4:0]  r, s;
    iv = imm;
    r  = rd[4:0];
    s  = rs1[4:0];
    case (k)
      K_JAL:   enc = {iv[20], iv[10:1], iv[11], iv[19:12], r, 7'b1101111};
      K_JALR:  enc = {iv[11:0], s, 3'b000, r, 7'b1100111};
      K_BR:    enc = {iv[12], iv[10:5], 5'd0, 5'd0, 3'b000, iv[4:1], iv[11], 7'b1100011};
      K_HALT:  enc = 32'h0000007F;
      default: enc = {iv[11:0], s, 3'b000, r, 7'b0010011};
    endcase
  endfunction

  task automatic predict(input kind_t k, input int imm, input int rd, input logic [31:0] rv,
                         input bit tk, input bit st);
    logic [31:0] t;
    bit          redir;
    e_plus    = (m_pc + 32'd4) % 2048;
    e_lwe     = (m_state == 0) && !st && (k == K_JAL || k == K_JALR) && (rd != 0);
    n_pc      = m_pc;
    n_state   = m_state;
    n_instret = m_instret;
    n_mis     = m_mis;
    if (m_state == 0 && !st) begin
      t     = m_pc + 32'd4;
      redir = 1'b0;
      if (k == K_JAL) begin
        t = m_pc + 32'(imm); redir = 1'b1;
      end else if (k == K_JALR) begin
        t = (rv + 32'(imm)) & 32'hFFFF_FFFE; redir = 1'b1;
      end else if (k == K_BR && tk) begin
        t = m_pc + 32'(imm); redir = 1'b1;
      end
      if (k == K_HALT) begin
        n_state   = 1;
        n_instret = m_instret + 1;
      end else if (redir && t[1]) begin
        n_state = 2;
        n_mis   = 1'b1;
      end else begin
        n_pc      = t % 2048;
        n_instret = m_instret + 1;
      end
    end
    e_next = n_pc;
  endtask

  task automatic drive(input logic [31:0] w, input kind_t k, input int imm, input int rd,
                       input logic [31:0] rv, input bit tk, input bit st);
    instr        = w;
    rs1_val      = rv;
    branch_taken = tk;
    stall        = st;
    predict(k, imm, rd, rv, tk, st);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_pc      = n_pc;
    m_state   = n_state;
    m_instret = n_instret;
    m_mis     = n_mis;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n     = 1'b1;
    m_pc      = 0;
    m_state   = 0;
    m_instret = 0;
    m_mis     = 1'b0;
  endtask

  task automatic test_reset();
    instr = 32'h00500293;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (pc !== 11'h000) begin n_fail++; $display("FAIL reset_pc got %h exp 000", pc); end
    n_tests++; if (run !== 1'b1) begin n_fail++; $display("FAIL reset_run got %b exp 1", run); end
    n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret got %0d exp 0", instret); end
    n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    n_tests++; if (w2_pc !== 11'h7F8) begin n_fail++; $display("FAIL reset_pc_param got %h exp 7f8", w2_pc); end
    #1;
    rst_n     = 1'b1;
    m_pc      = 0;
    m_state   = 0;
    m_instret = 0;
    m_mis     = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 2; i++) begin
      drive(32'h00500293, K_ALU, 5, 5, 32'd0, 1'b0, 1'b0);
      n_tests++; if (pc_next !== 11'(4 * i)) begin n_fail++; $display("FAIL seq_pc_next[%0d] got %h exp %h", i, pc_next, 4 * i); end
      tick();
    end
    n_tests++; if (pc !== 11'h008) begin n_fail++; $display("FAIL seq_pc got %h exp 008", pc); end
    n_tests++; if (instret !== 32'd2) begin n_fail++; $display("FAIL seq_instret got %0d exp 2", instret); end
  endtask

  task automatic test_jal();
    drive(32'h00c000ef, K_JAL, 12, 1, 32'd0, 1'b0, 1'b0);
    n_tests++; if (pc_next !== 11'h014) begin n_fail++; $display("FAIL jal_pc_next got %h exp 014", pc_next); end
    n_tests++; if (link_addr !== 32'h0000000C) begin n_fail++; $display("FAIL jal_link got %h exp 0000000c", link_addr); end
    n_tests++; if (link_we !== 1'b1) begin n_fail++; $display("FAIL jal_link_we got %b exp 1", link_we); end
    tick();
    n_tests++; if (pc !== 11'h014) begin n_fail++; $display("FAIL jal_pc got %h exp 014", pc); end
  endtask

  task automatic test_jalr();
    drive(32'h00008067, K_JALR, 0, 0, 32'h0000000C, 1'b0, 1'b0);
    n_tests++; if (pc_next !== 11'h00C) begin n_fail++; $display("FAIL jalr_pc_next got %h exp 00c", pc_next); end
    n_tests++; if (link_we !== 1'b0) begin n_fail++; $display("FAIL jalr_link_we got %b exp 0", link_we); end
    tick();
    n_tests++; if (pc !== 11'h00C) begin n_fail++; $display("FAIL jalr_pc got %h exp 00c", pc); end
  endtask

  task automatic test_branch_stall();
    drive(32'h00500293, K_ALU, 5, 5, 32'd0, 1'b0, 1'b0);
    tick();
    drive(32'hFE000EE3, K_BR, -4, 0, 32'd0, 1'b1, 1'b1);
    n_tests++; if (pc_next !== 11'h010) begin n_fail++; $display("FAIL br_stall_pc_next got %h exp 010", pc_next); end
    tick();
    n_tests++; if (pc !== 11'h010) begin n_fail++; $display("FAIL br_stall_pc got %h exp 010", pc); end
    n_tests++; if (instret !== 32'd5) begin n_fail++; $display("FAIL br_stall_instret got %0d exp 5", instret); end
    drive(32'hFE000EE3, K_BR, -4, 0, 32'd0, 1'b1, 1'b0);
    n_tests++; if (pc_next !== 11'h00C) begin n_fail++; $display("FAIL br_taken_pc_next got %h exp 00c", pc_next); end
    tick();
    drive(32'hFE000EE3, K_BR, -4, 0, 32'd0, 1'b0, 1'b0);
    n_tests++; if (pc_next !== 11'h010) begin n_fail++; $display("FAIL br_not_taken got %h exp 010", pc_next); end
    tick();
    n_tests++; if (instret !== 32'd7) begin n_fail++; $display("FAIL br_instret got %0d exp 7", instret); end
  endtask

  task automatic test_halt();
    drive(32'h0000007F, K_HALT, 0, 0, 32'd0, 1'b0, 1'b0);
    n_tests++; if (pc_next !== 11'h010) begin n_fail++; $display("FAIL halt_pc_next got %h exp 010", pc_next); end
    tick();
    n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL halt_run got %b exp 0", run); end
    n_tests++; if (instret !== 32'd8) begin n_fail++; $display("FAIL halt_instret got %0d exp 8", instret); end
    for (int i = 0; i < 5; i++) begin
      drive(enc(K_JAL, 16, 1, 0), K_JAL, 16, 1, 32'd0, 1'b0, i[0]);
      n_tests++; if (link_we !== 1'b0) begin n_fail++; $display("FAIL halt_link_we[%0d] got %b exp 0", i, link_we); end
      tick();
      n_tests++; if (pc !== 11'h010 || instret !== 32'd8 || run !== 1'b0) begin
        n_fail++; $display("FAIL halt_frozen[%0d] got pc=%h instret=%0d run=%b exp pc=010 instret=8 run=0", i, pc, instret, run);
      end
    end
  endtask

  task automatic test_fault();
    apply_reset();
    drive(32'h00008067, K_JALR, 0, 0, 32'h00000002, 1'b0, 1'b1);
    tick();
    n_tests++; if (misalign !== 1'b0 || run !== 1'b1) begin
      n_fail++; $display("FAIL fault_stalled got misalign=%b run=%b exp 0 1", misalign, run);
    end
    drive(32'h00008067, K_JALR, 0, 0, 32'h00000002, 1'b0, 1'b0);
    n_tests++; if (pc_next !== 11'h000) begin n_fail++; $display("FAIL fault_pc_next got %h exp 000", pc_next); end
    tick();
    n_tests++; if (misalign !== 1'b1 || run !== 1'b0 || pc !== 11'h000 || instret !== 32'd0) begin
      n_fail++; $display("FAIL fault_state got misalign=%b run=%b pc=%h instret=%0d exp 1 0 000 0", misalign, run, pc, instret);
    end
    drive(32'h00500293, K_ALU, 5, 5, 32'd0, 1'b0, 1'b0);
    tick();
    n_tests++; if (misalign !== 1'b1 || pc !== 11'h000) begin
      n_fail++; $display("FAIL fault_sticky got misalign=%b pc=%h exp 1 000", misalign, pc);
    end
    apply_reset();
    n_tests++; if (pc !== 11'h000 || run !== 1'b1 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL fault_reset got pc=%h run=%b misalign=%b exp 000 1 0", pc, run, misalign);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(32'h00500293, K_ALU, 5, 5, 32'd0, 1'b0, 1'b0);
    tick();
    n_tests++; if (w2_pc !== 11'h7FC) begin n_fail++; $display("FAIL wrap_pc1 got %h exp 7fc", w2_pc); end
    n_tests++; if (w2_pc_plus !== 11'h000) begin n_fail++; $display("FAIL wrap_pc_plus got %h exp 000", w2_pc_plus); end
    drive(32'h00500293, K_ALU, 5, 5, 32'd0, 1'b0, 1'b0);
    tick();
    n_tests++; if (w2_pc !== 11'h000) begin n_fail++; $display("FAIL wrap_pc2 got %h exp 000", w2_pc); end
  endtask

  task automatic test_random();
    kind_t       k;
    int          imm, rd, rs1, sel;
    logic [31:0] rv;
    bit          tk, st;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_state != 0 && $urandom_range(0, 3) == 0) apply_reset();
      sel = $urandom_range(0, 99);
      k   = (sel < 35) ? K_ALU : (sel < 55) ? K_JAL : (sel < 75) ? K_JALR : (sel < 97) ? K_BR : K_HALT;
      rd  = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      tk  = $urandom_range(0, 1) == 1;
      st  = $urandom_range(0, 4) == 0;
      rv  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) rv = rv | 32'h2;
      if ($urandom_range(0, 1) == 1) rv = rv | 32'h1;
      case (k)
        K_JAL:   imm = (int'($urandom_range(0, 2047)) - 1024) * 4;
        K_JALR:  imm = (int'($urandom_range(0, 1023)) - 512) * 4;
        K_BR:    imm = (int'($urandom_range(0, 1023)) - 512) * 4;
        default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      if (k != K_ALU && k != K_HALT && $urandom_range(0, 9) == 0) imm = imm + 2;
      drive(enc(k, imm, rd, rs1), k, imm, rd, rv, tk, st);
      n_tests++; if (pc_next !== e_next[10:0]) begin n_fail++; $display("FAIL rnd_pc_next[%0d] got %h exp %h", i, pc_next, e_next[10:0]); end
      n_tests++; if (pc_plus !== e_plus[10:0] || link_addr !== e_plus) begin
        n_fail++; $display("FAIL rnd_plus[%0d] got %h/%h exp %h", i, pc_plus, link_addr, e_plus);
      end
      n_tests++; if (link_we !== e_lwe) begin n_fail++; $display("FAIL rnd_link_we[%0d] got %b exp %b", i, link_we, e_lwe); end
      tick();
      n_tests++; if (pc !== m_pc[10:0] || run !== (m_state == 0) || misalign !== m_mis || instret !== m_instret) begin
        n_fail++; $display("FAIL rnd_state[%0d] got pc=%h run=%b mis=%b ret=%0d exp pc=%h run=%b mis=%b ret=%0d",
                           i, pc, run, misalign, instret, m_pc[10:0], (m_state == 0), m_mis, m_instret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_jalr();
    test_branch_stall();
    test_halt();
    test_fault();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
